operand_fetch: RTL and testbench



---
 rtl/proc_pkg.sv | 18 +
 rtl/operand_fetch_if.sv | 29 ++
 rtl/reg_file_1r1w.sv | 28 ++
 rtl/operand_fetch.sv | 73 +++++++
 tb/tb_operand_fetch.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared datapath constants and the operand-fetch FSM encoding.
package proc_pkg;
    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ1 = 2'd1;
    localparam logic [1:0] ST_READ2 = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_READ1 = ST_READ1,
        S_READ2 = ST_READ2,
        S_HOLD  = ST_HOLD
    } state_e;
endpackage

// File: rtl/operand_fetch_if.sv
// Request, writeback and operand-pair signals of the operand fetch stage.
interface operand_fetch_if #(
    parameter int w  = proc_pkg::W,
    parameter int AW = proc_pkg::AW
);
    // Both handshakes complete on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and the pair is stable while op_valid is high.
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [w-1:0]  wb_data;
    logic [w-1:0]  numar1;
    logic [w-1:0]  numar2;
    logic          op_valid;
    logic          op_ready;

    modport master (
        output req_valid, src1, src2, wb_en, wb_addr, wb_data, op_ready,
        input  req_ready, numar1, numar2, op_valid
    );

    modport slave (
        input  req_valid, src1, src2, wb_en, wb_addr, wb_data, op_ready,
        output req_ready, numar1, numar2, op_valid
    );
endinterface

// File: rtl/reg_file_1r1w.sv
// Register file with one combinational read port and one synchronous write port.
module reg_file_1r1w #(
    parameter int w    = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [w-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [w-1:0]  rdata
);
    logic [w-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/operand_fetch.sv
// Fetches two source registers on consecutive cycles and holds the pair for the logic unit.
module operand_fetch
    import proc_pkg::*;
#(
    parameter int w    = W,
    parameter int NREG = proc_pkg::NREG,
    parameter int AW   = proc_pkg::AW
) (
    input  logic                clk,
    input  logic                rst,
    operand_fetch_if.slave      bus,
    output logic [1:0]          state_o
);
    state_e        state_q, state_d;
    logic [AW-1:0] src1_q, src2_q;
    logic [w-1:0]  numar1_q, numar2_q;
    logic [AW-1:0] raddr;
    logic [w-1:0]  rdata;
    logic [w-1:0]  rd_byp;

    assign raddr = (state_q == S_READ2) ? src2_q : src1_q;

    reg_file_1r1w #(
        .w    (w),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.wb_en),
        .waddr (bus.wb_addr),
        .wdata (bus.wb_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Write-first: a same-edge writeback to the index being read wins over the stored value.
    assign rd_byp = (bus.wb_en && (bus.wb_addr == raddr)) ? bus.wb_data : rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_READ1;
            S_READ1: state_d = S_READ2;
            S_READ2: state_d = S_HOLD;
            S_HOLD:  if (bus.op_ready) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            numar1_q <= '0;
            numar2_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.req_valid) begin
                src1_q <= bus.src1;
                src2_q <= bus.src2;
            end
            if (state_q == S_READ1) numar1_q <= rd_byp;
            if (state_q == S_READ2) numar2_q <= rd_byp;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.op_valid  = (state_q == S_HOLD);
    assign bus.numar1    = numar1_q;
    assign bus.numar2    = numar2_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a queue-based scoreboard on the operand handshake.
module tb_operand_fetch;
  import proc_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  operand_fetch_if #(.w(16), .AW(3)) bus ();

  operand_fetch #(.w(16), .NREG(8), .AW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: every completed operand handshake is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && bus.op_valid && bus.op_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected actual=%h required=none", {bus.numar1, bus.numar2});
      end else begin
        check("sb_pair", {bus.numar1, bus.numar2}, exp_q.pop_front());
      end
    end
  end

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    @(posedge clk); #1;
    bus.wb_en   = 1'b0;
  endtask

  task automatic fetch(input logic [2:0] s1, input logic [2:0] s2,
                       input logic [15:0] e1, input logic [15:0] e2,
                       input bit mid_wr, input logic [2:0] wa, input logic [15:0] wd,
                       input int hold_cycles);
    exp_q.push_back({e1, e2});
    bus.op_ready  = (hold_cycles == 0);
    bus.req_valid = 1'b1;
    bus.src1      = s1;
    bus.src2      = s2;
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("req_ready_drop", {31'd0, bus.req_ready}, 32'd0);
    check("state_read1", {30'd0, state_o}, {30'd0, ST_READ1});
    if (mid_wr) begin
      bus.wb_en   = 1'b1;
      bus.wb_addr = wa;
      bus.wb_data = wd;
    end
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    check("op_valid_early", {31'd0, bus.op_valid}, 32'd0);
    @(posedge clk); #1;
    // third edge counting the acceptance edge
    check("op_valid_rise", {31'd0, bus.op_valid}, 32'd1);
    check("or_result", {16'd0, bus.numar1 | bus.numar2}, {16'd0, e1 | e2});
    for (int i = 0; i < hold_cycles; i++) begin
      check("hold_valid", {31'd0, bus.op_valid}, 32'd1);
      check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("hold_pair", {bus.numar1, bus.numar2}, {e1, e2});
      if (i == 0) begin
        bus.wb_en     = 1'b1;
        bus.wb_addr   = s1;
        bus.wb_data   = 16'hFFFF;
        bus.req_valid = 1'b1;
        bus.src1      = 3'd1;
        bus.src2      = 3'd1;
      end
      @(posedge clk); #1;
      bus.wb_en = 1'b0;
    end
    bus.req_valid = 1'b0;
    if (hold_cycles > 0) begin
      check("hold_state", {30'd0, state_o}, {30'd0, ST_HOLD});
      check("hold_pair_end", {bus.numar1, bus.numar2}, {e1, e2});
      bus.op_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("back_idle", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("op_valid_drop", {31'd0, bus.op_valid}, 32'd0);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.op_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    check("rst_pair", {bus.numar1, bus.numar2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: fresh registers read as zero
    fetch(3'd2, 3'd5, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 0);

    // 2: plain read of two written registers
    write_reg(3'd2, 16'hFB01);
    write_reg(3'd5, 16'h3B61);
    fetch(3'd2, 3'd5, 16'hFB01, 16'h3B61, 1'b0, 3'd0, 16'h0, 0);

    // 3: bypass of a writeback landing on the READ1 edge
    fetch(3'd3, 3'd4, 16'h1234, 16'h0000, 1'b1, 3'd3, 16'h1234, 0);
    fetch(3'd3, 3'd3, 16'h1234, 16'h1234, 1'b0, 3'd0, 16'h0, 0);

    // 4: long hold with a write to src1 and a stray request
    fetch(3'd2, 3'd5, 16'hFB01, 16'h3B61, 1'b0, 3'd0, 16'h0, 5);
    fetch(3'd2, 3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 3'd0, 16'h0, 0);

    // 5: asynchronous reset in the middle of READ2
    bus.op_ready  = 1'b1;
    bus.req_valid = 1'b1;
    bus.src1      = 3'd2;
    bus.src2      = 3'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_state", {30'd0, state_o}, {30'd0, ST_READ2});
    check("pre_rst_numar1", {16'd0, bus.numar1}, {16'd0, 16'hFFFF});
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    check("arst_pair", {bus.numar1, bus.numar2}, 32'd0);
    check("arst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    fetch(3'd2, 3'd5, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 0);
    fetch(3'd3, 3'd1, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 0);

    // 6: same source for both operands
    write_reg(3'd7, 16'hA5A5);
    fetch(3'd7, 3'd7, 16'hA5A5, 16'hA5A5, 1'b0, 3'd0, 16'h0, 0);

    // register 0 is an ordinary register
    write_reg(3'd0, 16'h0F0F);
    fetch(3'd0, 3'd7, 16'h0F0F, 16'hA5A5, 1'b0, 3'd0, 16'h0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
